lcd_spi_write: RTL and testbench



---
 rtl/lcd_pkg.sv | 9 +
 rtl/lcd_sclk_tick.sv | 19 +
 rtl/lcd_spi_write.sv | 119 +++++++++++
 tb/tb_lcd_spi_write.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, SPI mode-0 polarities and FSM state type for the ST7735 SPI writer
package lcd_pkg;
  localparam logic [8:0] DATA_IDLE = 9'h100;
  localparam int DC_BIT = 8;
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_ACTIVE = 1'b0;
  localparam logic CS_IDLE = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_HOLD, S_DONE, S_GAP} lcd_spi_state_t;
endpackage

// File: rtl/lcd_sclk_tick.sv
// lcd_sclk_tick: one-cycle tick every CLK_DIV cycles while enabled, counter cleared when disabled
module lcd_sclk_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en_i,
  output logic tick_o
);
  localparam int W = $clog2(CLK_DIV + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = en_i && cnt_q == W'(CLK_DIV - 1);
  assign cnt_d = (!en_i || tick_o) ? '0 : cnt_q + 1'b1;
  // half-period counter, restarts at every tick and whenever disabled
  always_ff @(posedge sys_clk) begin
    if (sys_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/lcd_spi_write.sv
// lcd_spi_write: 9-bit word to ST7735 4-wire SPI (mode 0, MSB first); LCD_SPI_CS_BURST_EN keeps CS low across a stream
module lcd_spi_write
  import lcd_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       en_write,
  input  logic [8:0] init_data,
  output logic       wr_done,
  output logic       busy,
  output logic       lcd_cs,
  output logic       lcd_dc,
  output logic       lcd_sclk,
  output logic       lcd_mosi
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  lcd_spi_state_t state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d, dc_q, dc_d, done_q, done_d, busy_q, busy_d;
  logic tick, latch;

  lcd_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .en_i(state_q == S_SHIFT || state_q == S_HOLD),
    .tick_o(tick)
  );

  // next state: SCLK phase and MOSI advance only on ticks; the last GAP cycle may latch directly
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d = bit_q;
    gap_d = gap_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    dc_d = dc_q;
    latch = 1'b0;
    case (state_q)
      S_IDLE: latch = en_write;
      S_SHIFT: if (tick) begin
        sclk_d = ~sclk_q;
        if (sclk_q) begin
          if (bit_q == 3'd0) state_d = S_HOLD;
          else begin
            bit_d = bit_q - 3'd1;
            shreg_d = shreg_q << 1;
            mosi_d = shreg_q[6];
          end
        end
      end
      S_HOLD: if (tick) state_d = S_DONE;
      S_DONE: begin
        state_d = S_GAP;
        gap_d = '0;
      end
      S_GAP: if (gap_q == GW'(GAP_CYCLES - 1)) begin
        state_d = S_IDLE;
        latch = en_write;
      end else gap_d = gap_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (latch) begin
      state_d = S_SHIFT;
      shreg_d = init_data[7:0];
      bit_d = 3'd7;
      mosi_d = init_data[7];
      dc_d = init_data[DC_BIT];
      sclk_d = SCLK_IDLE;
    end
`ifdef LCD_SPI_CS_BURST_EN
    cs_d = ((state_q == S_GAP || state_q == S_IDLE) && !en_write) ? CS_IDLE :
           (state_d == S_GAP || state_d == S_IDLE) ? cs_q : CS_ACTIVE;
`else
    cs_d = (state_d == S_SHIFT || state_d == S_HOLD) ? CS_ACTIVE : CS_IDLE;
`endif
    done_d = state_d == S_DONE;
    busy_d = state_d != S_IDLE;
  end

  // state and registered outputs; reset aborts any byte in flight without a done pulse
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bit_q <= '0;
      gap_q <= '0;
      cs_q <= CS_IDLE;
      sclk_q <= SCLK_IDLE;
      mosi_q <= 1'b0;
      dc_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q <= bit_d;
      gap_q <= gap_d;
      cs_q <= cs_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      dc_q <= dc_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign wr_done = done_q;
  assign busy = busy_q;
  assign lcd_cs = cs_q;
  assign lcd_dc = dc_q;
  assign lcd_sclk = sclk_q;
  assign lcd_mosi = mosi_q;
endmodule

// File: tb/tb_lcd_spi_write.sv
// tb_lcd_spi_write: SPI-decoding monitor plus upstream model checking bytes, timing and reset behaviour
module tb_lcd_spi_write;
  import lcd_pkg::*;
  localparam int H = 2;
  localparam int G = 3;
  localparam int T_LAT = 17 * H;
  localparam int T_PER = 17 * H + 1 + G;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic en_write = 1'b0;
  logic [8:0] init_data = DATA_IDLE;
  logic wr_done, busy, lcd_cs, lcd_dc, lcd_sclk, lcd_mosi;
  int n_cmp = 0;
  int n_err = 0;
  int ncyc = 0;
  int nbits = 0;
  logic prev_sclk = 1'b0;
  logic rx_dc = 1'b0;
  logic dc_bad = 1'b0;
  logic [7:0] rx = '0;
  logic [8:0] got_q[$];
  int nb_q[$];
  int done_q[$];
  logic bad_q[$];
  logic [8:0] sq[$];
  logic [8:0] w;

  lcd_spi_write #(.CLK_DIV(H), .GAP_CYCLES(G)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .en_write(en_write),
    .init_data(init_data),
    .wr_done(wr_done),
    .busy(busy),
    .lcd_cs(lcd_cs),
    .lcd_dc(lcd_dc),
    .lcd_sclk(lcd_sclk),
    .lcd_mosi(lcd_mosi)
  );

  always #5 sys_clk = ~sys_clk;

  // LCD-side receiver: samples MOSI on rising SCLK with CS low, logs each byte at wr_done
  always @(negedge sys_clk) begin
    ncyc <= ncyc + 1;
    prev_sclk <= lcd_sclk;
    if (sys_rst) begin
      nbits <= 0;
      dc_bad <= 1'b0;
    end else begin
      if (lcd_sclk && !prev_sclk && !lcd_cs) begin
        rx <= {rx[6:0], lcd_mosi};
        nbits <= nbits + 1;
        if (nbits == 0) rx_dc <= lcd_dc;
      end
      if (!lcd_cs && nbits > 0 && lcd_dc !== rx_dc) dc_bad <= 1'b1;
      if (wr_done) begin
        got_q.push_back({rx_dc, rx});
        nb_q.push_back(nbits);
        bad_q.push_back(dc_bad);
        done_q.push_back(ncyc);
        nbits <= 0;
        dc_bad <= 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    got_q.delete();
    nb_q.delete();
    done_q.delete();
    bad_q.delete();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * T_PER && busy; i++) step();
    chk("idle", busy, 0);
  endtask

  task automatic send(input logic [8:0] wd, input bit churn);
    int t0, n;
    clear_q();
    init_data = wd;
    en_write = 1'b1;
    t0 = ncyc;
    step();
    en_write = 1'b0;
    chk("lat_cs", lcd_cs, CS_ACTIVE);
    chk("lat_dc", lcd_dc, wd[8]);
    chk("lat_mosi", lcd_mosi, wd[7]);
    chk("lat_sclk", lcd_sclk, 0);
    chk("lat_busy", busy, 1);
    n = 0;
    while (got_q.size() == 0 && n < 4 * T_PER) begin
      if (churn) init_data = 9'($urandom);
      step();
      n++;
    end
    chk("done_seen", got_q.size(), 1);
    if (got_q.size() != 0) begin
      chk("word", got_q[0], wd);
      chk("bits", nb_q[0], 8);
      chk("dc_stable", bad_q[0], 0);
      chk("latency", done_q[0] - t0, T_LAT);
`ifndef LCD_SPI_CS_BURST_EN
      chk("cs_at_done", lcd_cs, CS_IDLE);
`endif
    end
    init_data = DATA_IDLE;
    step();
    chk("done_pulse", wr_done, 0);
    wait_idle();
  endtask

  task automatic stream();
    int ptr, dly, n;
    logic cs_hi;
    ptr = 0;
    dly = 0;
    n = 0;
    cs_hi = 1'b0;
    clear_q();
    init_data = sq[0];
    en_write = 1'b1;
    while (ptr < sq.size() && n < sq.size() * T_PER + 50) begin
      step();
      n++;
      if (wr_done) begin
        ptr++;
        en_write = ptr < sq.size();
        dly = 2;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0 && ptr < sq.size()) init_data = sq[ptr];
      end
      if (lcd_cs && ptr < sq.size()) cs_hi = 1'b1;
    end
    en_write = 1'b0;
    chk("stream_count", got_q.size(), sq.size());
    for (int i = 0; i < got_q.size() && i < sq.size(); i++) begin
      chk("stream_word", got_q[i], sq[i]);
      chk("stream_bits", nb_q[i], 8);
      if (i > 0) chk("stream_period", done_q[i] - done_q[i-1], T_PER);
    end
`ifdef LCD_SPI_CS_BURST_EN
    chk("burst_cs_low", cs_hi, 0);
`else
    chk("gap_cs_high", cs_hi, 1);
`endif
    step();
    step();
    chk("stream_cs_end", lcd_cs, CS_IDLE);
    init_data = DATA_IDLE;
    wait_idle();
  endtask

  initial begin
    repeat (3) step();
    chk("rst_cs", lcd_cs, 1);
    chk("rst_sclk", lcd_sclk, 0);
    chk("rst_mosi", lcd_mosi, 0);
    chk("rst_dc", lcd_dc, 0);
    chk("rst_done", wr_done, 0);
    chk("rst_busy", busy, 0);
    sys_rst = 1'b0;
    step();
    send(9'h011, 1'b0);
    send(9'h1A5, 1'b0);
    sq = '{9'h0B1, 9'h101, 9'h12C};
    stream();
    send(9'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) send(9'($urandom), 1'b0);
    sq.delete();
    for (int i = 0; i < 5; i++) sq.push_back(9'($urandom));
    stream();
    clear_q();
    w = 9'($urandom);
    init_data = w;
    en_write = 1'b1;
    step();
    en_write = 1'b0;
    for (int i = 0; i < 4 * T_PER && nbits < 4; i++) step();
    chk("rst_at_bit4", nbits, 4);
    sys_rst = 1'b1;
    step();
    chk("mid_rst_cs", lcd_cs, 1);
    chk("mid_rst_sclk", lcd_sclk, 0);
    chk("mid_rst_done", wr_done, 0);
    chk("mid_rst_busy", busy, 0);
    sys_rst = 1'b0;
    repeat (2 * T_PER) step();
    chk("mid_rst_no_done", got_q.size(), 0);
    send(9'($urandom), 1'b0);
    send(DATA_IDLE, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
